// File: rtl/spi_sub.sv
// SPI subordinate endpoint (mode 0, MSB first). It oversamples sclk/cs/mosi on
// the system clock and shifts received bits into rx_data. It returns a preloaded
// word on miso. Back-to-back words are supported while cs stays low.
module spi_sub #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sclk,
   input  logic                  cs,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Synchronizer chains plus one edge-detect flop per edge-sensitive input
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   cs_prev_q;

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   logic sclk_rise;
   logic sclk_fall;
   logic cs_fall;
   logic cs_rise;

   // Protocol state
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  word_done_q, word_done_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  tx_ready_q, tx_ready_d;
   logic                  miso_q, miso_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  underrun_q, underrun_d;
   logic                  busy_q, busy_d;
   logic                  load_now;

   // Input synchronizers; cs chain clears low so a cs held low across reset
   // does not look like a fresh falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   // Synced levels and single-cycle edge strobes
   always_comb begin
      sclk_s    = sclk_sync_q[SYNC_STAGES-1];
      cs_s      = cs_sync_q[SYNC_STAGES-1];
      mosi_s    = mosi_sync_q[SYNC_STAGES-1];
      sclk_rise = sclk_s & ~sclk_prev_q;
      sclk_fall = ~sclk_s & sclk_prev_q;
      cs_fall   = ~cs_s & cs_prev_q;
      cs_rise   = cs_s & ~cs_prev_q;
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         word_done_q <= 1'b0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         tx_ready_q  <= 1'b1;
         miso_q      <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         word_done_q <= word_done_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         tx_ready_q  <= tx_ready_d;
         miso_q      <= miso_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state: frame FSM, shifters, word load, then holding-register write
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      word_done_d = word_done_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      tx_ready_d  = tx_ready_q;
      miso_d      = miso_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      load_now    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            miso_d      = 1'b0;
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
            if (cs_fall) begin
               state_d  = ST_ACTIVE;
               load_now = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               // End of frame wins over any same-cycle sclk edge; partial word dropped
               state_d     = ST_IDLE;
               miso_d      = 1'b0;
               bit_cnt_d   = '0;
               word_done_d = 1'b0;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
               if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  rx_data_d   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                  rx_valid_d  = 1'b1;
                  bit_cnt_d   = '0;
                  word_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (sclk_fall) begin
               if (word_done_q) begin
                  word_done_d = 1'b0;
                  load_now    = 1'b1;
               end else begin
                  tx_shift_d = tx_shift_q << 1;
                  miso_d     = tx_shift_q[DATA_WIDTH-2];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Word load: take the holding register if full, otherwise send zeros
      if (load_now) begin
         if (!tx_ready_q) begin
            tx_shift_d = hold_q;
            tx_ready_d = 1'b1;
         end else begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
         end
         miso_d = tx_shift_d[DATA_WIDTH-1];
      end

      // Holding write sees the post-load ready flag, so a same-cycle load frees room
      if (tx_load && tx_ready_d) begin
         hold_d     = tx_data;
         tx_ready_d = 1'b0;
      end
   end

   // Busy tracks the frame state one cycle behind the FSM decision
   always_comb begin
      busy_d = (state_d == ST_ACTIVE);
   end

   // Registered outputs
   always_comb begin
      miso        = miso_q;
      tx_ready    = tx_ready_q;
      rx_data     = rx_data_q;
      rx_valid    = rx_valid_q;
      tx_underrun = underrun_q;
      busy        = busy_q;
   end

endmodule
